// File: rtl/remote_comm_pkg.sv
// ============================================================================
// Module  : remote_comm_pkg
// Brief   : Shared types and constants for the remote_comm host-side link.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package remote_comm_pkg;

    // Two-byte command sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cmd_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_t;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_POS  = 8'h5A;

    // Index of the stop bit within a 10-bit 8N1 frame (start = 0)
    localparam logic [3:0] LAST_BIT  = 4'd9;

endpackage

`default_nettype wire

// File: rtl/remote_comm_uart_xcvr.sv
// ============================================================================
// Module  : remote_comm_uart_xcvr
// Brief   : Independent 8N1 UART transmitter and receiver sharing one baud.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module remote_comm_uart_xcvr
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_o,
    output logic       tx_done_o,
    input  logic       rx_i,
    input  logic       clr_rdy_i,
    output logic       rx_rdy_o,
    output logic [7:0] rx_data_o
);

    localparam int                CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0]  BAUD_HALF = CNT_W'(BAUD_DIV / 2);

    // ------------------------------------------------------------------ TX
    tx_state_t          tx_state_q, tx_state_d;
    logic [9:0]         tx_shift_q, tx_shift_d;
    logic [CNT_W-1:0]   tx_baud_q,  tx_baud_d;
    logic [3:0]         tx_bit_q,   tx_bit_d;

    assign tx_o      = tx_shift_q[0];
    assign tx_done_o = (tx_state_q == TX_SEND) && (tx_baud_q == BAUD_LAST)
                       && (tx_bit_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        case (tx_state_q)
            TX_IDLE: ;
            TX_SEND: begin
                if (tx_baud_q == BAUD_LAST) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_IDLE;
                        tx_shift_d = '1;
                        tx_bit_d   = '0;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // A load may coincide with the final stop-bit cycle, giving gapless bytes
        if (trmt_i) begin
            tx_state_d = TX_SEND;
            tx_shift_d = {1'b1, tx_data_i, 1'b0};
            tx_baud_d  = '0;
            tx_bit_d   = '0;
        end
    end

    // ------------------------------------------------------------------ RX
    logic               rx_meta_q, rx_sync_q, rx_prev_q;
    logic               rx_fall;
    rx_state_t          rx_state_q, rx_state_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]   rx_baud_q,  rx_baud_d;
    logic [3:0]         rx_bit_q,   rx_bit_d;
    logic               rx_rdy_q,   rx_rdy_d;
    logic [7:0]         rx_data_q,  rx_data_d;

    // Edge (not level) start detection keeps a low line after a framing error from re-triggering
    assign rx_fall   = rx_prev_q & ~rx_sync_q;
    assign rx_rdy_o  = rx_rdy_q;
    assign rx_data_o = rx_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_baud_q  <= '0;
            rx_bit_q   <= '0;
            rx_rdy_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_rdy_q   <= rx_rdy_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_data_d  = rx_data_q;
        rx_rdy_d   = clr_rdy_i ? 1'b0 : rx_rdy_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_RECV;
                    rx_baud_d  = BAUD_HALF;
                    rx_bit_d   = '0;
                    rx_rdy_d   = 1'b0;
                end
            end
            RX_RECV: begin
                if (rx_baud_q == BAUD_LAST) begin
                    rx_baud_d = '0;
                    rx_bit_d  = rx_bit_q + 4'd1;
                    if (rx_bit_q == LAST_BIT) begin
                        rx_state_d = RX_IDLE;
                        rx_bit_d   = '0;
                        if (rx_sync_q) begin
                            rx_data_d = rx_shift_q;
                            rx_rdy_d  = 1'b1;
                        end
                    end else if (rx_bit_q != 4'd0) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/remote_comm.sv
// ============================================================================
// Module  : remote_comm
// Brief   : Sends a 16-bit command as two UART bytes and reports robot responses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    cmd_state_t  state_q, state_d;
    logic [7:0]  low_q, low_d;
    logic        cmd_sent_q, cmd_sent_d;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        clr_rdy;

    remote_comm_uart_xcvr #(
        .BAUD_DIV (BAUD_DIV)
    ) u_xcvr (
        .clk       (clk),
        .rst       (rst),
        .trmt_i    (trmt),
        .tx_data_i (tx_data),
        .tx_o      (TX),
        .tx_done_o (tx_done),
        .rx_i      (RX),
        .clr_rdy_i (clr_rdy),
        .rx_rdy_o  (resp_rdy),
        .rx_data_o (resp)
    );

    assign cmd_sent = cmd_sent_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            low_q      <= '0;
            cmd_sent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            low_q      <= low_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        low_d      = low_q;
        cmd_sent_d = cmd_sent_q;
        trmt       = 1'b0;
        tx_data    = cmd[15:8];
        clr_rdy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_cmd) begin
                    low_d      = cmd[7:0];
                    cmd_sent_d = 1'b0;
                    trmt       = 1'b1;
                    clr_rdy    = 1'b1;
                    state_d    = HIGH;
                end
            end
            HIGH: begin
                tx_data = low_q;
                if (tx_done) begin
                    trmt    = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                tx_data = low_q;
                if (tx_done) begin
                    cmd_sent_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_remote_comm.sv
// ============================================================================
// Module  : tb_remote_comm
// Brief   : Randomized self-checking bench for remote_comm with a bit-level link model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int BD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        send_cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_resp;

    always #5 clk = ~clk;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX       (RX),
        .TX       (TX),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; RX = 1'b1; send_cmd = 1'b0; cmd = '0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (TX !== 1'b1)       begin errors++; $display("FAIL reset_tx got %b exp 1", TX); end
        if (cmd_sent !== 1'b0) begin errors++; $display("FAIL reset_cmd_sent got %b exp 0", cmd_sent); end
        if (resp_rdy !== 1'b0) begin errors++; $display("FAIL reset_resp_rdy got %b exp 0", resp_rdy); end
        if (resp !== 8'h00)    begin errors++; $display("FAIL reset_resp got %h exp 00", resp); end
        model_resp = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Sends c, decodes TX at mid-bit from the serial timeline and checks the cmd_sent cycle.
    task automatic send_and_check(input logic [15:0] c, input bit poke);
        logic [19:0] bits;
        int          sent_at;
        bits    = '1;
        sent_at = -1;
        @(negedge clk);
        cmd = c; send_cmd = 1'b1;
        for (int k = 0; k <= 20*BD + 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                send_cmd = 1'b0;
                checks++;
                if (TX !== 1'b0) begin errors++; $display("FAIL tx_start_next_cycle got %b exp 0", TX); end
            end
            if (poke && k == 100) begin cmd = 16'hFFFF; send_cmd = 1'b1; end
            if (poke && k == 101) send_cmd = 1'b0;
            if ((k % BD) == BD/2 && k < 20*BD) bits[k/BD] = TX;
            if (cmd_sent === 1'b1 && sent_at < 0) sent_at = k;
        end
        checks += 7;
        if (bits[0] !== 1'b0 || bits[10] !== 1'b0)
            begin errors++; $display("FAIL tx_start_bits got %b%b exp 00", bits[0], bits[10]); end
        if (bits[9] !== 1'b1 || bits[19] !== 1'b1)
            begin errors++; $display("FAIL tx_stop_bits got %b%b exp 11", bits[9], bits[19]); end
        if (bits[8:1] !== c[15:8])
            begin errors++; $display("FAIL tx_high_byte got %h exp %h", bits[8:1], c[15:8]); end
        if (bits[18:11] !== c[7:0])
            begin errors++; $display("FAIL tx_low_byte got %h exp %h", bits[18:11], c[7:0]); end
        if (sent_at != 20*BD)
            begin errors++; $display("FAIL cmd_sent_cycle got %0d exp %0d", sent_at, 20*BD); end
        if (cmd_sent !== 1'b1)
            begin errors++; $display("FAIL cmd_sent_hold got %b exp 1", cmd_sent); end
        if (TX !== 1'b1)
            begin errors++; $display("FAIL tx_idle_after got %b exp 1", TX); end
    endtask

    // Drives one 8N1 frame on RX, starting at a falling clock edge, and checks the result.
    task automatic drive_rx(input logic [7:0] d, input bit stop_ok);
        logic [9:0] fr;
        fr = {stop_ok, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            RX = fr[b];
            repeat (BD) @(negedge clk);
            if (b == 0) begin
                checks++;
                if (resp_rdy !== 1'b0) begin errors++; $display("FAIL rdy_clr_on_start got %b exp 0", resp_rdy); end
            end
        end
        RX = 1'b1;
        if (stop_ok) model_resp = d;
        checks += 2;
        if (resp_rdy !== stop_ok)
            begin errors++; $display("FAIL rx_rdy byte %h got %b exp %b", d, resp_rdy, stop_ok); end
        if (resp !== model_resp)
            begin errors++; $display("FAIL rx_resp byte %h got %h exp %h", d, resp, model_resp); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_cmd();
        send_and_check(16'h4022, 1'b0);
    endtask

    task automatic test_busy_reject();
        send_and_check(16'h4022, 1'b1);
    endtask

    task automatic test_random_cmds();
        for (int i = 0; i < 3; i++) send_and_check(16'($urandom), 1'b0);
    endtask

    task automatic test_responses();
        drive_rx(RESP_DONE, 1'b1);
        drive_rx(RESP_POS, 1'b1);
        drive_rx(8'h3C, 1'b0);
        for (int i = 0; i < 6; i++) drive_rx(8'($urandom), ($urandom_range(0, 3) != 0));
    endtask

    task automatic test_full_duplex();
        fork
            send_and_check(16'h0000, 1'b0);
            begin
                repeat (20) @(negedge clk);
                drive_rx(RESP_DONE, 1'b1);
            end
        join
    endtask

    task automatic test_reset_mid();
        logic [9:0] fr;
        int         bad;
        fr  = {1'b1, RESP_POS, 1'b0};
        bad = 0;
        @(negedge clk);
        cmd = 16'($urandom); send_cmd = 1'b1; RX = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            send_cmd = 1'b0;
            RX = fr[(k + 1) / BD];
        end
        rst = 1'b1; RX = 1'b1;
        @(negedge clk);
        model_resp = 8'h00;
        checks += 3;
        if (TX !== 1'b1)       begin errors++; $display("FAIL rst_mid_tx got %b exp 1", TX); end
        if (resp_rdy !== 1'b0) begin errors++; $display("FAIL rst_mid_rdy got %b exp 0", resp_rdy); end
        if (resp !== 8'h00)    begin errors++; $display("FAIL rst_mid_resp got %h exp 00", resp); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (resp_rdy !== 1'b0 || TX !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d bad cycles exp 0", bad); end
        send_and_check(16'($urandom), 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_cmd();
        test_busy_reject();
        test_random_cmds();
        test_responses();
        test_full_duplex();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/remote_comm.md
Name: remote_comm

Overview:
- Host-side command transmitter and response receiver for the Knight's Tour system.
- Takes a 16-bit command and serializes it over a UART TX line as two 8N1 bytes, high byte first.
- Receives single-byte responses from the robot on a UART RX line and presents each byte with a ready flag, e.g. 8'hA5 (done/calibrated) and 8'h5A (tour move in progress).
- Sits in the bench/remote side and talks to the KnightsTour top over the TX/RX pair.

Parameters:
- BAUD_DIV, 2604, clocks per UART bit (50 MHz / 19200 baud).

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- RX  input  1  serial in from robot; idles high; asynchronous to clk
- TX  output  1  serial out to robot; idles high
- cmd  input  16  command word, sampled when send_cmd is high
- send_cmd  input  1  one-cycle request to transmit cmd
- cmd_sent  output  1  high once both bytes of the last command have completed
- resp_rdy  output  1  high when resp holds a newly received byte
- resp  output  8  last received response byte

Behaviour:
- Reset values:
  - TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00.
  - TX state machine in IDLE; RX state machine in IDLE.
  - Baud and bit counters cleared.
- UART framing:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly BAUD_DIV clocks.
- Command FSM states: IDLE, HIGH, LOW.
  - IDLE: on send_cmd=1, capture cmd[7:0] in a holding register, clear cmd_sent, and start transmitting cmd[15:8]; go to HIGH.
  - The start bit appears on TX in the cycle after send_cmd is sampled.
  - HIGH: when the high byte's stop bit completes, start the low byte in the next cycle (no idle gap); go to LOW.
  - LOW: when the low byte's stop bit completes, set cmd_sent=1 and go to IDLE.
  - cmd_sent stays high until the next accepted send_cmd.
  - send_cmd while in HIGH or LOW is ignored; cmd is not re-sampled.
- Receiver:
  - RX passes through two flops before use (metastability).
  - In idle, a sampled 0 starts a frame; data is sampled at mid-bit, BAUD_DIV/2 clocks after the falling edge and then every BAUD_DIV clocks.
  - After the 8 data bits are shifted in (LSB first), sample the stop bit.
  - Stop bit = 1: load resp and set resp_rdy=1 that cycle. Stop bit = 0 (framing error): discard the byte; resp and resp_rdy are unchanged.
  - resp_rdy clears on detection of the next start bit or on an accepted send_cmd.
  - resp holds its value until overwritten by the next valid byte.
- Simultaneous events:
  - RX and TX are fully independent; full-duplex operation is required.
  - A byte completing on RX in the same cycle as send_cmd: resp_rdy=1 wins that cycle, so the response is not lost.
- Reset mid-operation: both directions abort immediately, TX returns high the next cycle, and no partial byte is reported.
- Counters: baud counter ceil(log2(BAUD_DIV)) bits; bit counter 4 bits.

Decomposition:
- Shared package: the command FSM state enum (IDLE/HIGH/LOW) and the response constants RESP_DONE=8'hA5 and RESP_POS=8'h5A.
- One natural sub-module: uart_xcvr, combining TX (trmt, tx_data, tx_done) and RX (rx_rdy, rx_data, clr_rdy), both parameterized by BAUD_DIV.
- remote_comm itself holds only the two-byte sequencer and the output flags.

Test Plan (BAUD_DIV=16 for simulation):
- Reset: assert rst for 2 cycles -> TX=1, cmd_sent=0, resp_rdy=0, resp=8'h00.
- Single command: send_cmd with cmd=16'h4022.
  - TX goes low the next cycle; bytes 8'h40 then 8'h22 decode correctly on a model receiver.
  - cmd_sent rises exactly 320 cycles after send_cmd (2 × 10 bits × 16 clocks).
- Busy rejection: second send_cmd with cmd=16'hFFFF mid-transfer -> only 8'h40 and 8'h22 are transmitted; cmd_sent still rises once at cycle 320.
- Response receive: drive an 8N1 frame 8'hA5 on RX -> resp=8'hA5 and resp_rdy=1 after the stop-bit sample; a following frame 8'h5A clears resp_rdy at its start bit, then sets resp=8'h5A.
- Framing error: frame with data 8'h3C and stop bit 0 -> resp_rdy stays 0 and resp keeps its previous value.
- Full duplex and reset: receive 8'hA5 while sending 16'h0000 -> both complete correctly; asserting rst mid-byte -> TX=1 the next cycle and no spurious resp_rdy.
